// File: rtl/hpm_snapshot_ctrl.sv
// Arbitrates the HPM counter-bank CSR port between the core and a snapshot engine
// that samples each counter, optionally clears it, and streams {index, value} records.
//
// state | meaning
// IDLE  | waiting for a trigger or a timer tick
// READ  | sample counter idx into snap_q
// CLEAR | write back the increments that arrived after the sample
// PUSH  | present {idx, snap_q} until the sink accepts it
module hpm_snapshot_ctrl #(
  parameter int CSR_ADDR_WIDTH   = 12,
  parameter int XLEN             = 64,
  parameter int HPM_NUM_COUNTERS = 29,
  parameter int PERIOD_WIDTH     = 32
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      core_req_i,
  input  logic [CSR_ADDR_WIDTH-1:0] core_addr_i,
  input  logic                      core_we_i,
  input  logic [XLEN-1:0]           core_data_i,
  output logic [XLEN-1:0]           core_data_o,
  output logic [CSR_ADDR_WIDTH-1:0] hpm_addr_o,
  output logic                      hpm_we_o,
  output logic [XLEN-1:0]           hpm_wdata_o,
  input  logic [XLEN-1:0]           hpm_data_i,
  input  logic [PERIOD_WIDTH-1:0]   period_i,
  input  logic                      clear_on_read_i,
  input  logic                      trigger_i,
  output logic                      snap_valid_o,
  input  logic                      snap_ready_i,
  output logic [4:0]                snap_idx_o,
  output logic [XLEN-1:0]           snap_data_o,
  output logic                      snap_last_o,
  output logic                      busy_o,
  output logic                      missed_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_CLEAR, ST_PUSH} state_e;

  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MHPM_COUNTER_3 = CSR_ADDR_WIDTH'(12'hB03);
  localparam logic [4:0]                FIRST_IDX          = 5'd3;
  localparam logic [4:0]                LAST_IDX           = 5'(HPM_NUM_COUNTERS + 2);

  state_e                    r_state;
  state_e                    w_state_nxt;
  logic [4:0]                r_idx;
  logic [XLEN-1:0]           r_snap_q;
  logic                      r_core_hit;
  logic [PERIOD_WIDTH-1:0]   r_timer;

  logic                      w_tick;
  logic                      w_start;
  logic                      w_last;
  logic                      w_eng_access;
  logic                      w_eng_we;
  logic [XLEN-1:0]           w_eng_wdata;
  logic [CSR_ADDR_WIDTH-1:0] w_eng_addr;

  assign w_tick     = (r_timer == PERIOD_WIDTH'(1));
  assign w_start    = trigger_i | w_tick;
  assign w_last     = (r_idx == LAST_IDX);
  assign w_eng_addr = CSR_MHPM_COUNTER_3 + CSR_ADDR_WIDTH'(r_idx) - CSR_ADDR_WIDTH'(FIRST_IDX);

  // Reloads at 1 (tick) and at 0, so period_i=0 parks the timer at 0.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_timer <= '0;
    end else if (r_timer <= PERIOD_WIDTH'(1)) begin
      r_timer <= period_i;
    end else begin
      r_timer <= r_timer - PERIOD_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_eng_access = 1'b0;
    w_eng_we     = 1'b0;
    w_eng_wdata  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        if (!core_req_i) begin
          w_eng_access = 1'b1;
          w_state_nxt  = clear_on_read_i ? ST_CLEAR : ST_PUSH;
        end
      end
      ST_CLEAR: begin
        if (!core_req_i) begin
          w_state_nxt = ST_PUSH;
          // A core write to this counter during CLEAR owns its value now.
          if (!r_core_hit) begin
            w_eng_access = 1'b1;
            w_eng_we     = 1'b1;
            w_eng_wdata  = hpm_data_i - r_snap_q;
          end
        end
      end
      ST_PUSH: begin
        if (snap_ready_i) w_state_nxt = w_last ? ST_IDLE : ST_READ;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_idx      <= FIRST_IDX;
      r_snap_q   <= '0;
      r_core_hit <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) r_idx <= FIRST_IDX;
        end
        ST_READ: begin
          r_core_hit <= 1'b0;
          if (!core_req_i) r_snap_q <= hpm_data_i;
        end
        ST_CLEAR: begin
          if (core_req_i) begin
            if (core_we_i && (core_addr_i == w_eng_addr)) r_core_hit <= 1'b1;
          end else begin
            r_core_hit <= 1'b0;
          end
        end
        ST_PUSH: begin
          if (snap_ready_i && !w_last) r_idx <= r_idx + 5'd1;
        end
        default: r_core_hit <= 1'b0;
      endcase
    end
  end

  always_comb begin
    hpm_addr_o  = '0;
    hpm_we_o    = 1'b0;
    hpm_wdata_o = '0;
    if (core_req_i) begin
      hpm_addr_o  = core_addr_i;
      hpm_we_o    = core_we_i;
      hpm_wdata_o = core_data_i;
    end else if (w_eng_access) begin
      hpm_addr_o  = w_eng_addr;
      hpm_we_o    = w_eng_we;
      hpm_wdata_o = w_eng_wdata;
    end
  end

  assign core_data_o  = hpm_data_i;
  assign snap_valid_o = (r_state == ST_PUSH);
  assign snap_idx_o   = r_idx;
  assign snap_data_o  = r_snap_q;
  assign snap_last_o  = snap_valid_o & w_last;
  assign busy_o       = (r_state != ST_IDLE);
  assign missed_o     = busy_o & w_start;

endmodule

// File: tb/tb_hpm_snapshot_ctrl.sv
// Scoreboard bench for hpm_snapshot_ctrl: a behavioural counter bank, expected
// records queued at trigger time, and a forked monitor that checks every handshake.
module tb_hpm_snapshot_ctrl;
  localparam logic [11:0] BASE = 12'hB00;

  typedef struct {
    logic [4:0]  idx;
    logic [63:0] data;
    logic        last;
    logic        any;
  } rec_t;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rstn_i;
  logic        core_req_i, core_we_i;
  logic [11:0] core_addr_i;
  logic [63:0] core_data_i, core_data_o;
  logic [11:0] hpm_addr_o;
  logic        hpm_we_o;
  logic [63:0] hpm_wdata_o, hpm_data_i;
  logic [31:0] period_i;
  logic        clear_on_read_i, trigger_i, snap_valid_o, snap_ready_i;
  logic [4:0]  snap_idx_o;
  logic [63:0] snap_data_o;
  logic        snap_last_o, busy_o, missed_o;

  logic [63:0] core_data_b;
  logic [11:0] hpm_addr_b;
  logic        hpm_we_b;
  logic [63:0] hpm_wdata_b, hpm_data_b;
  logic        trigger_b, valid_b, last_b, busy_b, missed_b;
  logic [4:0]  idx_b;
  logic [63:0] data_b, bank_b3;

  logic [63:0] bank  [0:31];
  logic [63:0] model [0:31];
  logic [63:0] rec_data [0:31];
  int          hs_cyc [0:31];
  rec_t        exp_q[$];
  rec_t        exp_b_q[$];

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic        inc5 = 1'b0;
  int          inc_n = 0;
  int          eng_wr5_n = 0;
  logic [63:0] eng_wr5 = '0;

  hpm_snapshot_ctrl dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_we_i(core_we_i),
    .core_data_i(core_data_i), .core_data_o(core_data_o),
    .hpm_addr_o(hpm_addr_o), .hpm_we_o(hpm_we_o), .hpm_wdata_o(hpm_wdata_o),
    .hpm_data_i(hpm_data_i), .period_i(period_i), .clear_on_read_i(clear_on_read_i),
    .trigger_i(trigger_i), .snap_valid_o(snap_valid_o), .snap_ready_i(snap_ready_i),
    .snap_idx_o(snap_idx_o), .snap_data_o(snap_data_o), .snap_last_o(snap_last_o),
    .busy_o(busy_o), .missed_o(missed_o)
  );

  hpm_snapshot_ctrl #(.HPM_NUM_COUNTERS(1)) dut_one (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .core_req_i(1'b0), .core_addr_i(12'h000), .core_we_i(1'b0),
    .core_data_i(64'd0), .core_data_o(core_data_b),
    .hpm_addr_o(hpm_addr_b), .hpm_we_o(hpm_we_b), .hpm_wdata_o(hpm_wdata_b),
    .hpm_data_i(hpm_data_b), .period_i(32'd0), .clear_on_read_i(1'b0),
    .trigger_i(trigger_b), .snap_valid_o(valid_b), .snap_ready_i(1'b1),
    .snap_idx_o(idx_b), .snap_data_o(data_b), .snap_last_o(last_b),
    .busy_o(busy_b), .missed_o(missed_b)
  );

  always_comb begin
    hpm_data_i = '0;
    if (hpm_addr_o[11:5] == 7'h58 && hpm_addr_o[4:0] >= 5'd3) hpm_data_i = bank[hpm_addr_o[4:0]];
  end
  assign hpm_data_b = (hpm_addr_b == 12'hB03) ? bank_b3 : 64'd0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // One clock: port intent is sampled mid-cycle, the bank commits just after the edge.
  task automatic step();
    logic        we, eng;
    logic [11:0] a;
    logic [63:0] wd;
    @(negedge clk_i);
    we = hpm_we_o; a = hpm_addr_o; wd = hpm_wdata_o; eng = !core_req_i;
    @(posedge clk_i);
    #1;
    cyc++;
    if (we && a[11:5] == 7'h58 && a[4:0] >= 5'd3) begin
      bank[a[4:0]] = wd;
      if (eng && a[4:0] == 5'd5) begin
        eng_wr5_n++;
        eng_wr5 = wd;
      end
    end
    if (inc5) begin
      bank[5] = bank[5] + 64'd1;
      inc_n++;
    end
  endtask

  task automatic preload();
    for (int i = 3; i <= 31; i++) begin
      bank[i]  = 64'(100 * i);
      model[i] = bank[i];
    end
  endtask

  task automatic push_all(input logic any5);
    rec_t r;
    for (int i = 3; i <= 31; i++) begin
      r.idx = 5'(i); r.data = model[i]; r.last = (i == 31); r.any = any5 && (i == 5);
      exp_q.push_back(r);
    end
  endtask

  task automatic run_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy_o && n < budget) begin
      step();
      n++;
    end
    if (busy_o) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, budget);
    end
  endtask

  task automatic mon_a();
    rec_t        e;
    logic        held;
    logic [4:0]  h_idx;
    logic [63:0] h_data;
    logic        h_last;
    held = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rstn_i) begin
        held = 1'b0;
      end else if (snap_valid_o) begin
        if (held) begin
          chk("hold_idx", 64'(snap_idx_o), 64'(h_idx));
          chk("hold_data", snap_data_o, h_data);
          chk("hold_last", 64'(snap_last_o), 64'(h_last));
        end
        if (snap_ready_i) begin
          held = 1'b0;
          hs_cyc[snap_idx_o]   = cyc;
          rec_data[snap_idx_o] = snap_data_o;
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_record: got idx %0d, expected none", snap_idx_o);
          end else begin
            e = exp_q.pop_front();
            chk("rec_idx", 64'(snap_idx_o), 64'(e.idx));
            if (!e.any) chk("rec_data", snap_data_o, e.data);
            chk("rec_last", 64'(snap_last_o), 64'(e.last));
          end
        end else begin
          held = 1'b1; h_idx = snap_idx_o; h_data = snap_data_o; h_last = snap_last_o;
        end
      end else if (held) begin
        held = 1'b0;
        n_vec++; n_err++;
        $display("FAIL valid_dropped: valid 0 before handshake, expected 1");
      end
    end
  endtask

  task automatic mon_b();
    rec_t e;
    forever begin
      @(negedge clk_i);
      if (rstn_i && valid_b) begin
        if (exp_b_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL one_unexpected: got idx %0d, expected none", idx_b);
        end else begin
          e = exp_b_q.pop_front();
          chk("one_idx", 64'(idx_b), 64'(e.idx));
          chk("one_data", data_b, e.data);
          chk("one_last", 64'(last_b), 64'(e.last));
        end
      end
    end
  endtask

  initial begin
    int   n, nbad;
    logic found, clr;

    rstn_i = 1'b0; core_req_i = 1'b0; core_we_i = 1'b0; core_addr_i = '0; core_data_i = '0;
    period_i = '0; clear_on_read_i = 1'b0; trigger_i = 1'b0; snap_ready_i = 1'b1;
    trigger_b = 1'b0; bank_b3 = '0;
    for (int i = 0; i <= 31; i++) begin
      bank[i] = '0; model[i] = '0; rec_data[i] = '0; hs_cyc[i] = 0;
    end
    fork
      mon_a();
      mon_b();
    join_none

    repeat (3) step();
    chk("rst_valid", 64'(snap_valid_o), 64'd0);
    chk("rst_last", 64'(snap_last_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_missed", 64'(missed_o), 64'd0);
    chk("rst_we", 64'(hpm_we_o), 64'd0);
    chk("rst_addr", 64'(hpm_addr_o), 64'd0);
    chk("rst_wdata", hpm_wdata_o, 64'd0);
    chk("rst_sdata", snap_data_o, 64'd0);
    chk("rst_idx", 64'(snap_idx_o), 64'd3);
    rstn_i = 1'b1;
    step();

    // Basic snapshot, no clear
    preload();
    push_all(1'b0);
    trigger_i = 1'b1; step(); trigger_i = 1'b0;
    chk("t1_busy_t1", 64'(busy_o), 64'd1);
    chk("t1_valid_t1", 64'(snap_valid_o), 64'd0);
    step();
    chk("t1_valid_t2", 64'(snap_valid_o), 64'd1);
    run_idle("t1", 200);
    chk("t1_left", 64'(exp_q.size()), 64'd0);
    chk("t1_thru", 64'(hs_cyc[4] - hs_cyc[3]), 64'd2);
    nbad = 0;
    for (int i = 3; i <= 31; i++) if (bank[i] !== model[i]) nbad++;
    chk("t1_bank_kept", 64'(nbad), 64'd0);

    // Clear-on-read while counter 5 counts every cycle
    preload();
    clear_on_read_i = 1'b1; inc_n = 0; eng_wr5_n = 0;
    push_all(1'b1);
    inc5 = 1'b1;
    trigger_i = 1'b1; step(); trigger_i = 1'b0;
    chk("t2_busy_t1", 64'(busy_o), 64'd1);
    step();
    chk("t2_valid_t2", 64'(snap_valid_o), 64'd0);
    step();
    chk("t2_valid_t3", 64'(snap_valid_o), 64'd1);
    run_idle("t2", 300);
    inc5 = 1'b0;
    chk("t2_left", 64'(exp_q.size()), 64'd0);
    chk("t2_thru", 64'(hs_cyc[4] - hs_cyc[3]), 64'd3);
    chk("t2_wr5_count", 64'(eng_wr5_n), 64'd1);
    chk("t2_wr5_data", eng_wr5, 64'd1);
    chk("t2_conserved", rec_data[5] + bank[5], 64'd500 + 64'(inc_n));
    nbad = 0;
    for (int i = 3; i <= 31; i++) if (i != 5 && bank[i] !== 64'd0) nbad++;
    chk("t2_cleared", 64'(nbad), 64'd0);

    // Core writes the counter the engine is about to clear
    preload();
    eng_wr5_n = 0;
    push_all(1'b0);
    trigger_i = 1'b1; step(); trigger_i = 1'b0;
    found = 1'b0; n = 0;
    while (!found && n < 100) begin
      step(); n++;
      found = hpm_we_o && (hpm_addr_o == 12'hB05);
    end
    chk("t2b_found_clear", 64'(found), 64'd1);
    core_req_i = 1'b1; core_we_i = 1'b1; core_addr_i = 12'hB05; core_data_i = 64'd777;
    #1;
    chk("t2b_pass_addr", 64'(hpm_addr_o), 64'hB05);
    chk("t2b_pass_we", 64'(hpm_we_o), 64'd1);
    chk("t2b_pass_wdata", hpm_wdata_o, 64'd777);
    step();
    core_req_i = 1'b0; core_we_i = 1'b0;
    run_idle("t2b", 300);
    chk("t2b_left", 64'(exp_q.size()), 64'd0);
    chk("t2b_bank5", bank[5], 64'd777);
    chk("t2b_no_eng_wr", 64'(eng_wr5_n), 64'd0);
    chk("t2b_bank6", bank[6], 64'd0);

    // Core priority during READ of idx 7
    preload();
    clear_on_read_i = 1'b0;
    push_all(1'b0);
    trigger_i = 1'b1; step(); trigger_i = 1'b0;
    found = 1'b0; n = 0;
    while (!found && n < 100) begin
      found = (hpm_addr_o == 12'hB07) && !hpm_we_o;
      if (!found) begin step(); n++; end
    end
    chk("t3_found_read7", 64'(found), 64'd1);
    for (int k = 0; k < 4; k++) begin
      core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 12'hB0A;
      core_data_i = {$urandom, $urandom};
      #1;
      chk("t3_core_addr", 64'(hpm_addr_o), 64'hB0A);
      chk("t3_core_we", 64'(hpm_we_o), 64'd0);
      chk("t3_core_wdata", hpm_wdata_o, core_data_i);
      chk("t3_core_rdata", core_data_o, 64'd1000);
      step();
    end
    core_req_i = 1'b0;
    run_idle("t3", 300);
    chk("t3_left", 64'(exp_q.size()), 64'd0);
    chk("t3_delay7", 64'(hs_cyc[7] - hs_cyc[6]), 64'd6);

    // Periodic start with backpressure and a dropped tick
    rstn_i = 1'b0; period_i = 32'd10; snap_ready_i = 1'b0;
    exp_q.delete();
    preload();
    push_all(1'b0);
    step(); step();
    rstn_i = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 10) chk("t4_busy_e10", 64'(busy_o), 64'd0);
      if (k == 11) chk("t4_busy_e11", 64'(busy_o), 64'd1);
      chk("t4_missed", 64'(missed_o), 64'(k == 20));
      if (k == 20) period_i = 32'd0;
    end
    chk("t4_held_valid", 64'(snap_valid_o), 64'd1);
    chk("t4_held_idx", 64'(snap_idx_o), 64'd3);
    snap_ready_i = 1'b1;
    run_idle("t4", 300);
    chk("t4_left", 64'(exp_q.size()), 64'd0);

    // period 0 and no trigger: engine stays idle
    nbad = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (busy_o || missed_o) nbad++;
    end
    chk("t5_period0_idle", 64'(nbad), 64'd0);

    // Single-counter instance
    bank_b3 = {$urandom, $urandom};
    exp_b_q.push_back('{idx: 5'd3, data: bank_b3, last: 1'b1, any: 1'b0});
    trigger_b = 1'b1; step(); trigger_b = 1'b0;
    chk("one_busy_t1", 64'(busy_b), 64'd1);
    step();
    chk("one_valid_t2", 64'(valid_b), 64'd1);
    step();
    chk("one_busy_t3", 64'(busy_b), 64'd0);
    chk("one_left", 64'(exp_b_q.size()), 64'd0);

    // Reset during PUSH
    preload();
    clear_on_read_i = 1'b1; snap_ready_i = 1'b0;
    push_all(1'b0);
    trigger_i = 1'b1; step(); trigger_i = 1'b0;
    n = 0;
    while (!snap_valid_o && n < 20) begin step(); n++; end
    chk("t6_in_push", 64'(snap_valid_o), 64'd1);
    rstn_i = 1'b0;
    #1;
    chk("t6_valid", 64'(snap_valid_o), 64'd0);
    chk("t6_last", 64'(snap_last_o), 64'd0);
    chk("t6_busy", 64'(busy_o), 64'd0);
    chk("t6_missed", 64'(missed_o), 64'd0);
    chk("t6_we", 64'(hpm_we_o), 64'd0);
    chk("t6_addr", 64'(hpm_addr_o), 64'd0);
    chk("t6_wdata", hpm_wdata_o, 64'd0);
    chk("t6_sdata", snap_data_o, 64'd0);
    chk("t6_idx", 64'(snap_idx_o), 64'd3);
    exp_q.delete();
    snap_ready_i = 1'b1;
    nbad = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (hpm_we_o) nbad++;
    end
    rstn_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (hpm_we_o || busy_o) nbad++;
    end
    chk("t6_quiet", 64'(nbad), 64'd0);

    // Randomized snapshots: random values, clear mode, ready and core reads
    for (int s = 0; s < 6; s++) begin
      for (int i = 3; i <= 31; i++) begin
        bank[i] = {$urandom, $urandom};
        model[i] = bank[i];
      end
      clr = 1'($urandom_range(0, 1));
      clear_on_read_i = clr;
      push_all(1'b0);
      core_req_i = 1'b0; snap_ready_i = 1'b1;
      trigger_i = 1'b1; step(); trigger_i = 1'b0;
      n = 0;
      while (busy_o && n < 3000) begin
        snap_ready_i = ($urandom_range(0, 3) != 0);
        core_req_i   = ($urandom_range(0, 3) == 0);
        core_we_i    = 1'b0;
        core_addr_i  = BASE + 12'($urandom_range(3, 31));
        #1;
        if (core_req_i) begin
          chk("rnd_core_addr", 64'(hpm_addr_o), 64'(core_addr_i));
          chk("rnd_core_we", 64'(hpm_we_o), 64'd0);
        end
        step(); n++;
      end
      if (busy_o) begin
        n_vec++; n_err++;
        $display("FAIL rnd_timeout: busy still 1 after %0d cycles, expected 0", n);
      end
      core_req_i = 1'b0; snap_ready_i = 1'b1;
      nbad = 0;
      for (int i = 3; i <= 31; i++) if (bank[i] !== (clr ? 64'd0 : model[i])) nbad++;
      chk("rnd_bank", 64'(nbad), 64'd0);
      chk("rnd_left", 64'(exp_q.size()), 64'd0);
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
